// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory-port signal bundle for mem_arbiter
interface mem_arbiter_if;
    logic        IReq;
    logic [31:0] IAdr;
    logic [31:0] IRData;
    logic        IAck;
    logic        DReq;
    logic        DWe;
    logic [31:0] DAdr;
    logic [31:0] DWData;
    logic [31:0] DRData;
    logic        DAck;
    logic        MemRE;
    logic        MemWE;
    logic [31:0] MemAdr;
    logic [31:0] MemWD;
    logic [31:0] MemRD;

    modport slave (
        input  IReq, IAdr, DReq, DWe, DAdr, DWData, MemRD,
        output IRData, IAck, DRData, DAck, MemRE, MemWE, MemAdr, MemWD
    );

    modport master (
        output IReq, IAdr, DReq, DWe, DAdr, DWData, MemRD,
        input  IRData, IAck, DRData, DAck, MemRE, MemWE, MemAdr, MemWD
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin I/D arbiter for a single-port memory with wait states
module mem_arbiter #(
    parameter int WAIT_STATES = 2
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_STATES);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_d_q, last_d_d;   // 1: D was served last
    logic          owner_d_q, owner_d_d; // 1: D owns the current access
    logic          we_q, we_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   wd_q, wd_d;
    logic [31:0]   irdata_q, irdata_d;
    logic [31:0]   drdata_q, drdata_d;
    logic          grant_d;

    // D wins when alone, or on a tie when I was served last.
    assign grant_d = bus.DReq & (~bus.IReq | ~last_d_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            last_d_q  <= 1'b0;
            owner_d_q <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            wd_q      <= '0;
            irdata_q  <= '0;
            drdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_d_q  <= last_d_d;
            owner_d_q <= owner_d_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            wd_q      <= wd_d;
            irdata_q  <= irdata_d;
            drdata_q  <= drdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d_d  = last_d_q;
        owner_d_d = owner_d_q;
        we_d      = we_q;
        adr_d     = adr_q;
        wd_d      = wd_q;
        irdata_d  = irdata_q;
        drdata_d  = drdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.IReq || bus.DReq) begin
                    owner_d_d = grant_d;
                    last_d_d  = grant_d;
                    adr_d     = grant_d ? bus.DAdr : bus.IAdr;
                    wd_d      = grant_d ? bus.DWData : wd_q;
                    we_d      = grant_d & bus.DWe;
                    cnt_d     = CNT_LOAD;
                    state_d   = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (owner_d_q) drdata_d = bus.MemRD;
                        else           irdata_d = bus.MemRD;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Write strobe only on the last ACCESS cycle so each write commits once.
    assign bus.MemRE  = (state_q == S_ACCESS) & ~we_q;
    assign bus.MemWE  = (state_q == S_ACCESS) & we_q & (cnt_q == '0);
    assign bus.MemAdr = adr_q;
    assign bus.MemWD  = wd_q;
    assign bus.IAck   = (state_q == S_RESP) & ~owner_d_q;
    assign bus.DAck   = (state_q == S_RESP) & owner_d_q;
    assign bus.IRData = irdata_q;
    assign bus.DRData = drdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if bif ();
    mem_arbiter_if bif0 ();

    mem_arbiter #(.WAIT_STATES(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    mem_arbiter #(.WAIT_STATES(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bif0.slave)
    );

    logic [31:0] mem  [0:255];
    logic [31:0] mem0 [0:255];
    logic        pl_en;
    logic        pl_sel;
    logic [7:0]  pl_idx;
    logic [31:0] pl_dat;

    assign bif.MemRD  = mem[bif.MemAdr[9:2]];
    assign bif0.MemRD = mem0[bif0.MemAdr[9:2]];

    always @(posedge clk) begin
        if (pl_en && !pl_sel)  mem[pl_idx] <= pl_dat;
        else if (bif.MemWE)    mem[bif.MemAdr[9:2]] <= bif.MemWD;
        if (pl_en && pl_sel)   mem0[pl_idx] <= pl_dat;
        else if (bif0.MemWE)   mem0[bif0.MemAdr[9:2]] <= bif0.MemWD;
    end

    int tests = 0;
    int fails = 0;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic preload(input logic sel, input logic [7:0] idx, input logic [31:0] dat);
        pl_en = 1'b1; pl_sel = sel; pl_idx = idx; pl_dat = dat;
        step();
        pl_en = 1'b0;
    endtask

    // Drives one D access on the WAIT_STATES=2 instance and records what the port did.
    task automatic run_d(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                         input int chg_cyc, input logic [31:0] adr2,
                         output int re_cnt, output int we_cnt, output int we_cyc,
                         output int ack_cyc, output int ack_cnt, output logic [31:0] rd,
                         output logic adr_ok, output int bad);
        re_cnt = 0; we_cnt = 0; we_cyc = -1; ack_cyc = -1; ack_cnt = 0;
        rd = '0; adr_ok = 1'b1; bad = 0;
        bif.DReq = 1'b1; bif.DWe = we; bif.DAdr = adr; bif.DWData = wd;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (bif.MemRE) begin
                re_cnt++;
                if (bif.MemAdr !== adr) adr_ok = 1'b0;
            end
            if (bif.MemWE) begin
                we_cnt++; we_cyc = c;
                if (bif.MemAdr !== adr) adr_ok = 1'b0;
            end
            if (bif.IAck) bad++;
            if (bif.DAck && bif.MemWE) bad++;
            if (bif.DAck) begin
                ack_cnt++; ack_cyc = c; rd = bif.DRData;
                bif.DReq = 1'b0;
            end
            if (c == chg_cyc) bif.DAdr = adr2;
        end
    endtask

    task automatic test_reset();
        step();
        tests++;
        if ({bif.IAck, bif.DAck, bif.MemRE, bif.MemWE} !== 4'b0) begin
            fails++; $display("FAIL reset_strobes: got %b want 0000", {bif.IAck, bif.DAck, bif.MemRE, bif.MemWE});
        end
        tests++;
        if (bif.MemAdr !== 32'h0 || bif.MemWD !== 32'h0) begin
            fails++; $display("FAIL reset_mem_bus: got adr %h wd %h want 0", bif.MemAdr, bif.MemWD);
        end
        tests++;
        if (bif.IRData !== 32'h0 || bif.DRData !== 32'h0) begin
            fails++; $display("FAIL reset_rdata: got I %h D %h want 0", bif.IRData, bif.DRData);
        end
        tests++;
        if ({bif0.IAck, bif0.DAck, bif0.MemRE, bif0.MemWE} !== 4'b0) begin
            fails++; $display("FAIL reset_ws0_strobes: got %b want 0000", {bif0.IAck, bif0.DAck, bif0.MemRE, bif0.MemWE});
        end
    endtask

    task automatic test_d_read();
        int re_cnt, we_cnt, we_cyc, ack_cyc, ack_cnt, bad;
        logic [31:0] rd;
        logic adr_ok;
        run_d(1'b0, 32'h100, 32'h0, -1, 32'h0, re_cnt, we_cnt, we_cyc, ack_cyc, ack_cnt, rd, adr_ok, bad);
        tests++;
        if (re_cnt !== 3) begin fails++; $display("FAIL dread_re_cycles: got %0d want 3", re_cnt); end
        tests++;
        if (ack_cyc !== 4 || ack_cnt !== 1) begin
            fails++; $display("FAIL dread_ack: got cycle %0d count %0d want 4/1", ack_cyc, ack_cnt);
        end
        tests++;
        if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL dread_data: got %h want deadbeef", rd); end
        tests++;
        if (!adr_ok || we_cnt !== 0 || bad !== 0) begin
            fails++; $display("FAIL dread_port: got adr_ok %0b we %0d bad %0d want 1/0/0", adr_ok, we_cnt, bad);
        end
    endtask

    task automatic test_d_write();
        int re_cnt, we_cnt, we_cyc, ack_cyc, ack_cnt, bad;
        logic [31:0] rd;
        logic adr_ok;
        run_d(1'b1, 32'h200, 32'h12345678, -1, 32'h0, re_cnt, we_cnt, we_cyc, ack_cyc, ack_cnt, rd, adr_ok, bad);
        tests++;
        if (we_cnt !== 1 || we_cyc !== 3) begin
            fails++; $display("FAIL dwrite_we: got count %0d cycle %0d want 1/3", we_cnt, we_cyc);
        end
        tests++;
        if (ack_cyc !== 4 || ack_cnt !== 1 || re_cnt !== 0 || bad !== 0 || !adr_ok) begin
            fails++; $display("FAIL dwrite_ack: got cycle %0d count %0d re %0d bad %0d adr_ok %0b want 4/1/0/0/1",
                              ack_cyc, ack_cnt, re_cnt, bad, adr_ok);
        end
        tests++;
        if (mem[8'h80] !== 32'h12345678) begin
            fails++; $display("FAIL dwrite_mem: got %h want 12345678", mem[8'h80]);
        end
        tests++;
        if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL dwrite_rdata_hold: got %h want deadbeef", rd); end
        run_d(1'b0, 32'h200, 32'h0, -1, 32'h0, re_cnt, we_cnt, we_cyc, ack_cyc, ack_cnt, rd, adr_ok, bad);
        tests++;
        if (rd !== 32'h12345678 || ack_cnt !== 1) begin
            fails++; $display("FAIL dwrite_readback: got %h acks %0d want 12345678/1", rd, ack_cnt);
        end
    endtask

    task automatic test_round_robin();
        int n = 0;
        int both = 0;
        int dat_err = 0;
        int side [0:7];
        int cyc [0:7];
        preload(1'b0, 8'h04, 32'h11112222);
        preload(1'b0, 8'h08, 32'h33334444);
        reset = 1'b1;
        step();
        reset = 1'b0;
        bif.IReq = 1'b1; bif.IAdr = 32'h10;
        bif.DReq = 1'b1; bif.DWe = 1'b0; bif.DAdr = 32'h20;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (bif.IAck && bif.DAck) both++;
            if ((bif.IAck || bif.DAck) && n < 8) begin
                side[n] = bif.DAck ? 1 : 0;
                cyc[n] = c;
                if (bif.DAck && bif.DRData !== 32'h33334444) dat_err++;
                if (bif.IAck && bif.IRData !== 32'h11112222) dat_err++;
                n++;
            end
        end
        bif.IReq = 1'b0; bif.DReq = 1'b0;
        step(); step(); step(); step(); step();
        tests++;
        if (n !== 4 || both !== 0) begin
            fails++; $display("FAIL rr_count: got acks %0d overlap %0d want 4/0", n, both);
        end else begin
            tests++;
            if (side[0] !== 1 || side[1] !== 0 || side[2] !== 1 || side[3] !== 0) begin
                fails++; $display("FAIL rr_order: got %0d%0d%0d%0d want 1010 (1=D)", side[0], side[1], side[2], side[3]);
            end
            tests++;
            if (cyc[0] !== 4 || cyc[1] !== 9 || cyc[2] !== 14 || cyc[3] !== 19) begin
                fails++; $display("FAIL rr_spacing: got %0d,%0d,%0d,%0d want 4,9,14,19", cyc[0], cyc[1], cyc[2], cyc[3]);
            end
        end
        tests++;
        if (dat_err !== 0) begin fails++; $display("FAIL rr_data: got %0d bad reads want 0", dat_err); end
    endtask

    task automatic test_reset_mid();
        int we_seen = 0;
        int ack_seen = 0;
        preload(1'b0, 8'hC0, 32'hAAAA5555);
        bif.DReq = 1'b1; bif.DWe = 1'b1; bif.DAdr = 32'h300; bif.DWData = 32'h5A5A5A5A;
        step();
        if (bif.MemWE) we_seen++;
        step();
        if (bif.MemWE) we_seen++;
        reset = 1'b1;
        #1;
        tests++;
        if ({bif.DAck, bif.MemRE, bif.MemWE} !== 3'b0 || bif.MemAdr !== 32'h0 || bif.MemWD !== 32'h0) begin
            fails++; $display("FAIL midreset_outputs: got strobes %b adr %h wd %h want 0", {bif.DAck, bif.MemRE, bif.MemWE}, bif.MemAdr, bif.MemWD);
        end
        tests++;
        if (bif.DRData !== 32'h0 || bif.IRData !== 32'h0) begin
            fails++; $display("FAIL midreset_rdata: got D %h I %h want 0", bif.DRData, bif.IRData);
        end
        bif.DReq = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (c == 2) reset = 1'b0;
            if (bif.MemWE) we_seen++;
            if (bif.DAck) ack_seen++;
        end
        tests++;
        if (we_seen !== 0 || ack_seen !== 0) begin
            fails++; $display("FAIL midreset_no_commit: got we %0d ack %0d want 0/0", we_seen, ack_seen);
        end
        tests++;
        if (mem[8'hC0] !== 32'hAAAA5555) begin
            fails++; $display("FAIL midreset_mem: got %h want aaaa5555", mem[8'hC0]);
        end
    endtask

    task automatic test_ws0();
        int re_cnt = 0;
        int acks = 0;
        int a1 = -1;
        int a2 = -1;
        int dat_err = 0;
        preload(1'b1, 8'h02, 32'hE3A00001);
        bif0.IReq = 1'b1; bif0.IAdr = 32'h8;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (bif0.MemRE) re_cnt++;
            if (bif0.DAck) dat_err++;
            if (bif0.IAck) begin
                if (bif0.IRData !== 32'hE3A00001) dat_err++;
                if (acks == 0) a1 = c; else a2 = c;
                acks++;
                if (acks == 2) bif0.IReq = 1'b0;
            end
        end
        tests++;
        if (a1 !== 2 || a2 !== 5) begin
            fails++; $display("FAIL ws0_ack_timing: got %0d,%0d want 2,5", a1, a2);
        end
        tests++;
        if (re_cnt !== 2 || acks !== 2) begin
            fails++; $display("FAIL ws0_re_cycles: got re %0d acks %0d want 2/2", re_cnt, acks);
        end
        tests++;
        if (dat_err !== 0) begin fails++; $display("FAIL ws0_data: got %0d errors want 0", dat_err); end
    endtask

    task automatic test_addr_change();
        int re_cnt, we_cnt, we_cyc, ack_cyc, ack_cnt, bad;
        logic [31:0] rd;
        logic adr_ok;
        preload(1'b0, 8'h41, 32'hCAFEF00D);
        run_d(1'b0, 32'h100, 32'h0, 1, 32'h104, re_cnt, we_cnt, we_cyc, ack_cyc, ack_cnt, rd, adr_ok, bad);
        tests++;
        if (!adr_ok || re_cnt !== 3) begin
            fails++; $display("FAIL adrchg_memadr: got adr_ok %0b re %0d want 1/3", adr_ok, re_cnt);
        end
        tests++;
        if (rd !== 32'hDEADBEEF || ack_cyc !== 4) begin
            fails++; $display("FAIL adrchg_data: got %h at cycle %0d want deadbeef at 4", rd, ack_cyc);
        end
    endtask

    initial begin
        reset = 1'b1;
        pl_en = 1'b0; pl_sel = 1'b0; pl_idx = '0; pl_dat = '0;
        bif.IReq = 1'b0; bif.IAdr = '0; bif.DReq = 1'b0; bif.DWe = 1'b0; bif.DAdr = '0; bif.DWData = '0;
        bif0.IReq = 1'b0; bif0.IAdr = '0; bif0.DReq = 1'b0; bif0.DWe = 1'b0; bif0.DAdr = '0; bif0.DWData = '0;
        step();
        test_reset();
        preload(1'b0, 8'h40, 32'hDEADBEEF);
        reset = 1'b0;
        step();
        test_d_read();
        test_d_write();
        test_round_robin();
        test_reset_mid();
        test_ws0();
        test_addr_change();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
